// File: rtl/joy_db9_pkg.sv
// rtl/joy_db9_pkg.sv - shared types, frame geometry and counter sizing for the DB9 joystick scanner
package joy_db9_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_CMP
  } state_t;

  localparam int FRAME_BITS = 24;
  localparam int JOY_BITS   = 12;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// rtl/joy_tick_gen.sv - DIV-cycle phase counter with sync clear and last-cycle tick
module joy_tick_gen
  import joy_db9_pkg::*;
#(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrapping on tick lets back-to-back phases run without an explicit clear.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/joy_db9_scanner.sv
// rtl/joy_db9_scanner.sv - drives the DB9 shift-register chain and publishes filtered joystick words
module joy_db9_scanner
  import joy_db9_pkg::*;
#(
  parameter int DIV    = 25,
  parameter int GAP    = 1000,
  parameter bit FILTER = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                joy_data,
  output logic                joy_clk,
  output logic                joy_load,
  output logic [JOY_BITS-1:0] joy1,
  output logic [JOY_BITS-1:0] joy2,
  output logic                frame_done,
  output logic                busy
);

  localparam int            GW       = clog2(GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam int            BW       = clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [FRAME_BITS-1:0]   prev_q, prev_d;
  logic [JOY_BITS-1:0]     joy1_q, joy1_d;
  logic [JOY_BITS-1:0]     joy2_q, joy2_d;
  logic                    joy_clk_q, joy_clk_d;
  logic                    joy_load_q, joy_load_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;
  logic                    tick;
  logic                    tick_clear;
  logic                    match;

  assign tick_clear = (state_q == ST_IDLE) || (state_q == ST_CMP);
  assign match      = !FILTER || (frame_q == prev_q);

  joy_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    prev_d  = prev_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;

    case (state_q)
      ST_IDLE: begin
        if (gap_q == GAP_LAST) begin
          if (enable) begin
            state_d = ST_LOAD;
            gap_d   = '0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_LOAD: begin
        if (tick) begin
          state_d = ST_SHIFT_LO;
          bit_d   = '0;
        end
      end
      ST_SHIFT_LO: begin
        // Sample just before the rising edge that advances the chain.
        if (tick) begin
          frame_d = {frame_q[FRAME_BITS-2:0], joy_data};
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_CMP;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_CMP: begin
        if (match) begin
          joy1_d = ~frame_q[FRAME_BITS-1 -: JOY_BITS];
          joy2_d = ~frame_q[JOY_BITS-1:0];
        end
        prev_d  = frame_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the next state so they line up cycle-for-cycle with it.
    joy_load_d   = (state_d != ST_LOAD);
    joy_clk_d    = (state_d != ST_SHIFT_LO);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_CMP) && match;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      bit_q        <= '0;
      frame_q      <= '0;
      prev_q       <= {FRAME_BITS{1'b1}};
      joy1_q       <= '0;
      joy2_q       <= '0;
      joy_clk_q    <= 1'b1;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joy1       = joy1_q;
  assign joy2       = joy2_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_joy_db9_scanner.sv
// tb/tb_joy_db9_scanner.sv - directed bench for joy_db9_scanner with behavioural PISO chain models
module tb_joy_db9_scanner;

  localparam int DIV_A = 2;
  localparam int GAP_A = 4;
  localparam int DIV_B = 3;
  localparam int GAP_B = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  always #5 clk = ~clk;

  logic        a_joy_data, a_joy_clk, a_joy_load, a_frame_done, a_busy;
  logic [11:0] a_joy1, a_joy2;
  logic        b_joy_data, b_joy_clk, b_joy_load, b_frame_done, b_busy;
  logic [11:0] b_joy1, b_joy2;

  joy_db9_scanner #(.DIV(DIV_A), .GAP(GAP_A), .FILTER(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(a_joy_data),
    .joy_clk(a_joy_clk), .joy_load(a_joy_load), .joy1(a_joy1), .joy2(a_joy2),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  joy_db9_scanner #(.DIV(DIV_B), .GAP(GAP_B), .FILTER(1'b0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(b_joy_data),
    .joy_clk(b_joy_clk), .joy_load(b_joy_load), .joy1(b_joy1), .joy2(b_joy2),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  // Chain models: parallel load while load is low, shift on joy_clk rising, MSB out first.
  logic [23:0] raw_a = 24'hFFFFFF;
  logic [23:0] raw_b = 24'hFFFFFF;
  logic [23:0] sr_a = 24'hFFFFFF;
  logic [23:0] sr_b = 24'hFFFFFF;

  always @(posedge a_joy_clk or negedge a_joy_load)
    if (!a_joy_load) sr_a <= raw_a;
    else             sr_a <= {sr_a[22:0], 1'b1};

  always @(posedge b_joy_clk or negedge b_joy_load)
    if (!b_joy_load) sr_b <= raw_b;
    else             sr_b <= {sr_b[22:0], 1'b1};

  assign a_joy_data = sr_a[23];
  assign b_joy_data = sr_b[23];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int w_cyc, w_load_start, w_load_len, w_falls, w_rises, w_dones;
  bit w_phase_ok, w_ended, w_aborted;

  // Follows dut_a from an idle point to the next end of frame (busy falling).
  task automatic watch_a(input int drop_fall, input int rst_rise);
    logic pclk, pload, pbusy;
    int run;
    w_cyc = 0; w_load_start = -1; w_load_len = 0; w_falls = 0; w_rises = 0;
    w_dones = 0; w_phase_ok = 1'b1; w_ended = 1'b0; w_aborted = 1'b0;
    pclk = a_joy_clk; pload = a_joy_load; pbusy = a_busy; run = 0;
    while (w_cyc < 1000) begin
      @(negedge clk);
      w_cyc++;
      if (!a_joy_load) begin
        w_load_len++;
        if (w_load_start < 0) w_load_start = w_cyc;
      end
      if (a_frame_done) w_dones++;
      if (a_joy_clk != pclk) begin
        if (!a_joy_clk) begin
          w_falls++;
          if (w_falls == 1) begin
            if (pload) w_phase_ok = 1'b0;
          end else if (run != DIV_A) begin
            w_phase_ok = 1'b0;
          end
          if (w_falls == drop_fall) enable = 1'b0;
        end else begin
          w_rises++;
          if (run != DIV_A) w_phase_ok = 1'b0;
          if (w_rises == rst_rise) begin
            reset = 1'b1;
            w_aborted = 1'b1;
            break;
          end
        end
        run = 1;
      end else begin
        run++;
      end
      if (pbusy && !a_busy) begin
        w_ended = 1'b1;
        break;
      end
      pclk = a_joy_clk; pload = a_joy_load; pbusy = a_busy;
    end
  endtask

  task automatic wait_b(output bit ended, output int dones);
    logic pbusy;
    ended = 1'b0; dones = 0; pbusy = b_busy;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_frame_done) dones++;
      if (pbusy && !b_busy) begin
        ended = 1'b1;
        break;
      end
      pbusy = b_busy;
    end
  endtask

  bit b_ended;
  int b_dones;
  int bad;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_joy_clk",    32'(a_joy_clk), 32'd1);
    chk("rst_joy_load",   32'(a_joy_load), 32'd1);
    chk("rst_joy1",       32'(a_joy1), 32'h0);
    chk("rst_joy2",       32'(a_joy2), 32'h0);
    chk("rst_frame_done", 32'(a_frame_done), 32'd0);
    chk("rst_busy",       32'(a_busy), 32'd0);
    chk("rst_b_joy_load", 32'(b_joy_load), 32'd1);
    reset = 1'b0;

    // First frame from an idle chain, FILTER=1
    watch_a(-1, -1);
    chk("f1_end",        32'(w_ended), 32'd1);
    chk("f1_load_start", w_load_start, GAP_A);
    chk("f1_load_len",   w_load_len, DIV_A);
    chk("f1_falls",      w_falls, 24);
    chk("f1_rises",      w_rises, 24);
    chk("f1_phases",     32'(w_phase_ok), 32'd1);
    chk("f1_dones",      w_dones, 1);
    chk("f1_period",     w_cyc, GAP_A + 49 * DIV_A + 1);
    chk("f1_joy1",       32'(a_joy1), 32'h0);
    chk("f1_joy2",       32'(a_joy2), 32'h0);
    chk("f1_done_pulse", 32'(a_frame_done), 32'd0);

    watch_a(-1, -1);
    chk("f2_period", w_cyc, 103);
    chk("f2_phases", 32'(w_phase_ok), 32'd1);

    // FILTER=0 instance, raw 7FEFFE
    wait_b(b_ended, b_dones);
    raw_b = 24'h7FEFFE;
    wait_b(b_ended, b_dones);
    chk("b_end",   32'(b_ended), 32'd1);
    chk("b_dones", b_dones, 1);
    chk("b_joy1",  32'(b_joy1), 32'h801);
    chk("b_joy2",  32'(b_joy2), 32'h001);
    chk("b_done_pulse", 32'(b_frame_done), 32'd0);

    // FILTER=1: single A frame must not reach the outputs, repeated A must
    watch_a(-1, -1);
    raw_a = 24'hFFF000;
    watch_a(-1, -1);
    chk("a_once_dones", w_dones, 0);
    chk("a_once_joy2",  32'(a_joy2), 32'h0);
    raw_a = 24'hFFFFFF;
    watch_a(-1, -1);
    chk("idle_after_a_dones", w_dones, 0);
    chk("idle_after_a_joy2",  32'(a_joy2), 32'h0);
    raw_a = 24'hFFF000;
    watch_a(-1, -1);
    chk("a_first_dones", w_dones, 0);
    chk("a_first_joy2",  32'(a_joy2), 32'h0);
    watch_a(-1, -1);
    chk("a_second_dones", w_dones, 1);
    chk("a_second_joy1",  32'(a_joy1), 32'h000);
    chk("a_second_joy2",  32'(a_joy2), 32'hFFF);

    // enable drops during bit 10: frame completes, then block idles
    raw_a = 24'h0F00F0;
    watch_a(-1, -1);
    chk("pre_drop_dones", w_dones, 0);
    watch_a(11, -1);
    chk("drop_end",   32'(w_ended), 32'd1);
    chk("drop_falls", w_falls, 24);
    chk("drop_dones", w_dones, 1);
    chk("drop_joy1",  32'(a_joy1), 32'hF0F);
    chk("drop_joy2",  32'(a_joy2), 32'hF0F);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!a_joy_load || a_busy) bad++;
    end
    chk("drop_idle_hold", bad, 0);

    // Reset during SHIFT_HI of bit 5
    enable = 1'b1;
    raw_a = 24'hFFFFFF;
    watch_a(-1, 6);
    chk("mid_rst_hit", 32'(w_aborted), 32'd1);
    #1;
    chk("mid_rst_joy_clk",  32'(a_joy_clk), 32'd1);
    chk("mid_rst_joy_load", 32'(a_joy_load), 32'd1);
    chk("mid_rst_joy1",     32'(a_joy1), 32'h0);
    chk("mid_rst_joy2",     32'(a_joy2), 32'h0);
    chk("mid_rst_busy",     32'(a_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_a(-1, -1);
    chk("post_rst_end",        32'(w_ended), 32'd1);
    chk("post_rst_period",     w_cyc, 103);
    chk("post_rst_load_start", w_load_start, GAP_A);
    chk("post_rst_falls",      w_falls, 24);
    chk("post_rst_phases",     32'(w_phase_ok), 32'd1);
    chk("post_rst_dones",      w_dones, 1);
    chk("post_rst_joy1",       32'(a_joy1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/joy_db9_scanner.md
# joy_db9_scanner

Serial scanner for the board's DB9 joystick shift-register chain (two 12-bit parallel-in/serial-out stages clocked by the FPGA). It drives the active-low load strobe and the shift clock, deserialises the 24-bit frame and optionally requires two consecutive identical frames before updating the outputs. It presents two active-high 12-bit joystick words to the core. It replaces pass-through reflection of the chain signals and sits between the board pins and the core's joystick inputs.

## Interface
Parameters:
- DIV, 25: system clocks per half-period of joy_clk and length of the load pulse; legal range ≥1.
- GAP, 1000: idle clocks between frames; legal range ≥1.
- FILTER, 1: 1 means outputs update only when two consecutive frames match; 0 means every frame updates the outputs.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  allows new frames to start.
- joy_data  in  1  serial data from the chain, active-low buttons.
- joy_clk  out  1  shift clock to the chain; idles high.
- joy_load  out  1  parallel-load strobe, active-low; idles high.
- joy1  out  12  first-received 12 bits, inverted to active-high.
- joy2  out  12  last-received 12 bits, inverted to active-high.
- frame_done  out  1  one-cycle pulse on the cycle joy1/joy2 are updated.
- busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, LOAD, SHIFT_LO, SHIFT_HI and CMP.
- IDLE: gap counter counts 0..GAP-1. After the cycle with count GAP-1, if enable=1, go to LOAD and clear the counter. Otherwise hold at GAP-1.
- LOAD: joy_load=0 for DIV cycles, then go to SHIFT_LO with bit counter = 0.
- SHIFT_LO: joy_clk=0 for DIV cycles. On the last of these cycles, shift joy_data into frame[0], with earlier bits moving toward the MSB.
- SHIFT_HI: joy_clk=1 for DIV cycles. The chain shifts on this rising edge. At the end of the phase, if bit counter = 23, go to CMP; otherwise increment the bit counter and return to SHIFT_LO.
- CMP lasts one cycle. If FILTER=0 or frame==prev, load joy1=~frame[23:12] and joy2=~frame[11:0], and assert frame_done. In both cases load prev=frame, then go to IDLE.
- prev resets to 24'hFFFFFF. As a result, an idle chain with FILTER=1 produces frame_done on the first frame with joy1 and joy2 unchanged at 0.
- If enable falls mid-frame, the current frame completes normally, and the block then holds in IDLE.
- joy_clk and joy_load are registered outputs with no combinational path from any input.

## Timing
- Reset values are: joy_clk=1, joy_load=1, joy1=0, joy2=0, frame_done=0, busy=0, state=IDLE, counters=0, frame=0, prev=FFFFFF.
- Reset asserted mid-frame forces all of the above immediately (asynchronously). The next frame starts GAP cycles after reset is released, if enable=1.
- Frame period with enable held high is GAP + DIV + 48·DIV + 1 clocks. With DIV=25 and GAP=1000, the period is 2226 clocks (≈44.5 µs at 50 MHz).
- Load pulse width is exactly DIV clocks. The first joy_clk falling edge is in the cycle after joy_load rises.
- The sample point is the last clock of each low phase, which is DIV-1 clocks after the falling edge. There are exactly 24 falling and 24 rising edges per frame.
- frame_done is high in the CMP cycle. joy1 and joy2 are valid from the next cycle.
- With DIV=1, joy_clk toggles every clock, which is the fastest legal rate.

## Structure
- Package joy_db9_pkg holds:
  - the state enum;
  - localparams FRAME_BITS=24 and JOY_BITS=12;
  - the counter width function clog2 used to size the DIV and GAP counters.
- One sub-module, joy_tick_gen: a DIV-cycle phase counter with sync clear, producing a last-cycle-of-phase tick. It is reused by the LOAD, SHIFT_LO and SHIFT_HI states.

## Test plan
- Reset release with the chain model idle (all 1s), FILTER=1: all reset values hold, joy_load pulses low for exactly DIV cycles after GAP cycles, frame_done pulses with joy1=0 and joy2=0.
- Chain model raw frame 24'h7FEFFE with FILTER=0: after one frame, joy1=12'h801 and joy2=12'h001, with a single frame_done pulse.
- FILTER=1: frame A=24'hFFF000 is sent once, then all 1s. The outputs never show joy2=12'hFFF. Sending A twice yields joy2=12'hFFF on the second CMP.
- DIV=2, GAP=4: the frame period measures 4+2+96+1=103 clocks, and joy_clk high and low phases are each 2 clocks.
- enable dropped during bit 10 of the shift: that frame completes and updates the outputs, then joy_load stays high and busy=0 indefinitely.
- reset pulsed during SHIFT_HI of bit 5: joy_clk=1, joy_load=1, joy1=0 and joy2=0 immediately; the next frame is a full, correct frame.
